// File: rtl/crt_pkg.sv
// Shared types and constants for the CRT bitmap capture/replay path.
package crt_pkg;

  localparam int unsigned CRT_COLS   = 40;
  localparam int unsigned CRT_ROWS   = 6;
  localparam int unsigned CRT_PIXELS = 240;

  typedef logic [5:0] crt_col_t;
  typedef logic [2:0] crt_row_t;
  typedef logic [7:0] crt_addr_t;

  // One bitmap write: linear pixel address plus the lit bit.
  typedef struct packed {
    crt_addr_t addr;
    logic      pixel;
  } crt_wr_t;

  // Row-major linear address of (row, col) in a bitmap that is cols wide.
  function automatic crt_addr_t crt_addr(input crt_row_t row, input crt_col_t col,
                                         input int unsigned cols);
    return crt_addr_t'(row) * crt_addr_t'(cols) + crt_addr_t'(col);
  endfunction

endpackage

// File: rtl/crt_bitbuf.sv
// Double-buffered CRT bitmap: two register banks, one write port into the back
// bank and one combinational read port from the front bank.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears both banks)
//   sel       - front bank select (0: bank0 front, bank1 back)
//   we, wr    - write strobe and address/pixel into the back bank
//   raddr     - read address into the front bank
//   rdata_c   - combinational read data (0 for addresses past the bitmap)
module crt_bitbuf
  import crt_pkg::*;
#(
  parameter int unsigned NPIX = CRT_PIXELS
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sel,
  input  logic      we,
  input  crt_wr_t   wr,
  input  crt_addr_t raddr,
  output logic      rdata_c
);

  logic [NPIX-1:0] bank0;
  logic [NPIX-1:0] bank1;

  // Back-bank write; the bank not selected as front takes the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (we) begin
      if (sel) bank0[wr.addr] <= wr.pixel;
      else     bank1[wr.addr] <= wr.pixel;
    end
  end

  // Front-bank read, guarded so out-of-bitmap addresses read as unlit.
  always_comb begin
    rdata_c = 1'b0;
    if (raddr < crt_addr_t'(NPIX)) rdata_c = sel ? bank1[raddr] : bank0[raddr];
  end

endmodule

// File: rtl/crt_upscaler.sv
// Captures the CRT solver's pixel stream into a double-buffered bitmap and
// replays it nearest-neighbour scaled by 2^SCALE_LOG2 onto the 640x480 raster.
// Ports:
//   clk_pix, rst_pix            - pixel clock, asynchronous active-high reset
//   crt_valid/crt_x/crt_y/crt_pixel - solver pixel write
//   frame                       - start-of-frame pulse (swap point)
//   sx, sy, de                  - raster position and data enable
//   pix_on                      - registered lit bit for previous (sx,sy)
//   pix_window                  - registered in-window flag for previous (sx,sy)
//   frame_ready                 - a complete capture has been swapped to display
//   wr_err                      - sticky out-of-range write flag
module crt_upscaler
  import crt_pkg::*;
#(
  parameter int unsigned COLS       = CRT_COLS,
  parameter int unsigned ROWS       = CRT_ROWS,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned ORIGIN_X   = 0,
  parameter int unsigned ORIGIN_Y   = 192,
  parameter int unsigned CORDW      = 10
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             crt_valid,
  input  logic [5:0]       crt_x,
  input  logic [2:0]       crt_y,
  input  logic             crt_pixel,
  input  logic             frame,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  output logic             pix_on,
  output logic             pix_window,
  output logic             frame_ready,
  output logic             wr_err
);

  localparam int unsigned DW    = CORDW + 1;
  localparam int unsigned WIN_W = COLS << SCALE_LOG2;
  localparam int unsigned WIN_H = ROWS << SCALE_LOG2;

  logic      sel;
  logic      pending;
  logic      wr_ok_c;
  logic      wr_last_c;
  logic      swap_c;
  crt_wr_t   wr;
  logic [DW-1:0] dx;
  logic [DW-1:0] dy;
  logic      win_c;
  crt_col_t  col;
  crt_row_t  row;
  crt_addr_t raddr;
  logic      rd_c;

  // Write qualification; the last pixel arms the swap.
  assign wr_ok_c   = crt_valid && (crt_x < crt_col_t'(COLS)) && (crt_y < crt_row_t'(ROWS));
  assign wr_last_c = wr_ok_c && (crt_x == crt_col_t'(COLS - 1)) && (crt_y == crt_row_t'(ROWS - 1));
  assign wr        = '{addr: crt_addr(crt_y, crt_x, COLS), pixel: crt_pixel};
  assign swap_c    = frame && pending;

  // Swap control. pending is sampled before this edge's last-pixel write, so a
  // last pixel coinciding with frame defers the swap to the next frame.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sel         <= 1'b0;
      pending     <= 1'b0;
      frame_ready <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      if (swap_c) begin
        sel         <= ~sel;
        frame_ready <= 1'b1;
      end
      if (wr_last_c)   pending <= 1'b1;
      else if (swap_c) pending <= 1'b0;
      if (crt_valid && !wr_ok_c) wr_err <= 1'b1;
    end
  end

  crt_bitbuf #(.NPIX(COLS * ROWS)) u_bitbuf (
    .clk     (clk_pix),
    .rst     (rst_pix),
    .sel     (sel),
    .we      (wr_ok_c),
    .wr      (wr),
    .raddr   (raddr),
    .rdata_c (rd_c)
  );

  // Window offsets one bit wider than the raster so left/above wraps to large.
  assign dx    = DW'(sx) - DW'(ORIGIN_X);
  assign dy    = DW'(sy) - DW'(ORIGIN_Y);
  assign win_c = de && (dx < DW'(WIN_W)) && (dy < DW'(WIN_H));
  assign col   = crt_col_t'(dx >> SCALE_LOG2);
  assign row   = crt_row_t'(dy >> SCALE_LOG2);
  assign raddr = crt_addr(row, col, COLS);

  // One-cycle display pipeline.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      pix_window <= 1'b0;
      pix_on     <= 1'b0;
    end else begin
      pix_window <= win_c;
      pix_on     <= win_c && rd_c;
    end
  end

endmodule
